// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and the two-pass 64-bit sequencer around it.
// Holds the operation codes, the sequencer state encoding and the flag bundle.
package alu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned ALUC_W = 4;
    localparam int unsigned ST_W   = 2;

    localparam logic [ALUC_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_SUB   = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [ALUC_W-1:0] ALU_ADD   = 4'b0100;
    localparam logic [ALUC_W-1:0] ALU_ADC   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALU_SBC   = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_NOR   = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_PASSB = 4'b1000;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_LO   = 2'd1;
    localparam logic [ST_W-1:0] ST_HI   = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // Upper pass must chain the carry/borrow out of the lower pass.
    function automatic logic [ALUC_W-1:0] hi_aluc(input logic [ALUC_W-1:0] aluc);
        logic [ALUC_W-1:0] res;
        res = aluc;
        if (aluc == ALU_ADD) res = ALU_ADC;
        if (aluc == ALU_SUB) res = ALU_SBC;
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; subtract carry is the inverted borrow, SBC computes a-b-(1-cin).
module alu
    import alu_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    input  logic [ALUC_W-1:0] i_aluc,
    input  logic              i_cin,
    output logic [HALF_W-1:0] o_out_c,
    output logic              o_cout_c,
    output logic              o_neg_c,
    output logic              o_zero_c,
    output logic              o_ovf_c
);

    localparam int unsigned SUM_W = HALF_W + 1;

    logic [HALF_W-1:0] w_b_eff;
    logic              w_cin_eff;
    logic              w_arith;
    logic [HALF_W-1:0] w_logic;
    logic [SUM_W-1:0]  w_sum;

    always_comb begin
        w_b_eff   = i_b;
        w_cin_eff = 1'b0;
        w_arith   = 1'b0;
        w_logic   = '0;
        case (i_aluc)
            ALU_ADD:   w_arith = 1'b1;
            ALU_ADC:   begin w_arith = 1'b1; w_cin_eff = i_cin; end
            ALU_SUB:   begin w_arith = 1'b1; w_b_eff = ~i_b; w_cin_eff = 1'b1; end
            ALU_SBC:   begin w_arith = 1'b1; w_b_eff = ~i_b; w_cin_eff = i_cin; end
            ALU_AND:   w_logic = i_a & i_b;
            ALU_OR:    w_logic = i_a | i_b;
            ALU_XOR:   w_logic = i_a ^ i_b;
            ALU_NOR:   w_logic = ~(i_a | i_b);
            ALU_PASSB: w_logic = i_b;
            default:   w_logic = '0;
        endcase
    end

    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + SUM_W'(w_cin_eff);
    assign o_out_c  = w_arith ? w_sum[HALF_W-1:0] : w_logic;
    assign o_cout_c = w_arith & w_sum[HALF_W];
    assign o_neg_c  = o_out_c[HALF_W-1];
    assign o_zero_c = (o_out_c == '0);
    assign o_ovf_c  = w_arith & (i_a[HALF_W-1] == w_b_eff[HALF_W-1])
                              & (w_sum[HALF_W-1] != i_a[HALF_W-1]);

endmodule

// File: rtl/alu_seq.sv
// Runs 32-bit ops in one ALU pass and 64-bit ops as a low then high pass,
// chaining the carry; one transaction in flight, result held until accepted.
module alu_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wide,
    input  logic [ALUC_W-1:0] req_aluc,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_n,
    output logic              rsp_z,
    output logic              rsp_c,
    output logic              rsp_v
);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic              r_wide;
    logic [ALUC_W-1:0] r_aluc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_cin;
    logic [DATA_W-1:0] r_rsp_data;
    alu_flags_t        r_flags;
    logic              r_rsp_valid;
    logic              r_req_ready;

    logic              w_hi;
    logic [HALF_W-1:0] w_alu_a;
    logic [HALF_W-1:0] w_alu_b;
    logic [ALUC_W-1:0] w_alu_aluc;
    logic              w_alu_cin;
    logic [HALF_W-1:0] w_alu_out;
    logic              w_alu_cout;
    logic              w_alu_neg;
    logic              w_alu_zero;
    logic              w_alu_ovf;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = ST_LO;
            ST_LO:   w_state_nxt = r_wide ? ST_HI : ST_DONE;
            ST_HI:   w_state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand/opcode/carry selection for the shared ALU.
    assign w_hi       = (r_state == ST_HI);
    assign w_alu_a    = w_hi ? r_a[DATA_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_alu_b    = w_hi ? r_b[DATA_W-1:HALF_W] : r_b[HALF_W-1:0];
    assign w_alu_aluc = w_hi ? hi_aluc(r_aluc) : r_aluc;
    assign w_alu_cin  = w_hi ? r_flags.c : r_cin;

    alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_aluc   (w_alu_aluc),
        .i_cin    (w_alu_cin),
        .o_out_c  (w_alu_out),
        .o_cout_c (w_alu_cout),
        .o_neg_c  (w_alu_neg),
        .o_zero_c (w_alu_zero),
        .o_ovf_c  (w_alu_ovf)
    );

    // Low pass fills the whole result; high pass overwrites the top half and merges Z.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wide      <= 1'b0;
            r_aluc      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_rsp_data  <= '0;
            r_flags     <= '0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_req_ready <= (w_state_nxt == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wide <= req_wide;
                        r_aluc <= req_aluc;
                        r_a    <= req_a;
                        r_b    <= req_b;
                        r_cin  <= req_cin;
                    end
                end
                ST_LO: begin
                    r_rsp_data <= {HALF_W'(0), w_alu_out};
                    r_flags    <= '{n: w_alu_neg, z: w_alu_zero, c: w_alu_cout, v: w_alu_ovf};
                end
                ST_HI: begin
                    r_rsp_data[DATA_W-1:HALF_W] <= w_alu_out;
                    r_flags <= '{n: w_alu_neg, z: w_alu_zero & r_flags.z,
                                 c: w_alu_cout, v: w_alu_ovf};
                end
                default: ;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_n     = r_flags.n;
    assign rsp_z     = r_flags.z;
    assign rsp_c     = r_flags.c;
    assign rsp_v     = r_flags.v;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations queued at request time, compared on each response handshake.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  nzcv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wide;
    logic [3:0]  req_aluc;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_n, rsp_z, rsp_c, rsp_v;

    exp_t sb_q[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wide  (req_wide),
        .req_aluc  (req_aluc),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Whole-width reference: a 64-bit op is one 65-bit sum, not two chained passes.
    function automatic exp_t model(input logic wide, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [63:0] bb, r;
        logic [64:0] s64;
        logic [32:0] s32;
        logic        c0, ar, c, v, sa, sb, sr;
        exp_t        e;
        bb = b; c0 = 1'b0; ar = 1'b1; r = '0; c = 1'b0;
        case (op)
            ALU_ADD:   ;
            ALU_ADC:   c0 = ci;
            ALU_SUB:   begin bb = ~b; c0 = 1'b1; end
            ALU_SBC:   begin bb = ~b; c0 = ci; end
            ALU_AND:   begin ar = 1'b0; r = a & b; end
            ALU_OR:    begin ar = 1'b0; r = a | b; end
            ALU_XOR:   begin ar = 1'b0; r = a ^ b; end
            ALU_NOR:   begin ar = 1'b0; r = ~(a | b); end
            ALU_PASSB: begin ar = 1'b0; r = b; end
            default:   ar = 1'b0;
        endcase
        if (ar) begin
            if (wide) begin
                s64 = {1'b0, a} + {1'b0, bb} + 65'(c0);
                r = s64[63:0]; c = s64[64];
            end else begin
                s32 = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(c0);
                r = {32'h0, s32[31:0]}; c = s32[32];
            end
        end else if (!wide) begin
            r[63:32] = 32'h0;
        end
        sa = wide ? a[63]  : a[31];
        sb = wide ? bb[63] : bb[31];
        sr = wide ? r[63]  : r[31];
        v  = ar && (sa == sb) && (sr != sa);
        e.data = r;
        e.nzcv = {sr, (r == 64'h0), c, v};
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                m_e = sb_q.pop_front();
                check("rsp_data", rsp_data, m_e.data);
                check("rsp_nzcv", 64'({rsp_n, rsp_z, rsp_c, rsp_v}), 64'(m_e.nzcv));
            end
        end
    end

    task automatic send(input logic wide, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic ci, input int hold,
                        input logic early, input exp_t e);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wide = wide; req_aluc = op;
        req_a = a; req_b = b; req_cin = ci; rsp_ready = early;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_cin = ~ci; req_aluc = ~op;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("latency", 64'(lat), wide ? 64'd3 : 64'd2);
        check("req_ready_busy", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data", rsp_data, e.data);
            check("hold_nzcv", 64'({rsp_n, rsp_z, rsp_c, rsp_v}), 64'(e.nzcv));
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("idle_after", 64'(req_ready), 64'd1);
        check("valid_after", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops [9];
        logic [3:0]  op;
        logic        wide;
        logic [63:0] a, b;
        logic        ci;
        int          hold;
        logic        early;
        ops = '{ALU_AND, ALU_OR, ALU_SUB, ALU_XOR, ALU_ADD, ALU_ADC, ALU_SBC, ALU_NOR, ALU_PASSB};

        // Reset with a request pending: reset must win, nothing accepted.
        reset = 1'b1; req_valid = 1'b1; req_wide = 1'b0; req_aluc = ALU_ADD;
        req_a = 64'h1; req_b = 64'h2; req_cin = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_nzcv", 64'({rsp_n, rsp_z, rsp_c, rsp_v}), 64'd0);
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_no_accept", 64'(rsp_valid), 64'd0);

        send(1'b0, ALU_ADD, 64'h0000000F, 64'h0000000A, 1'b0, 0, 1'b0, '{64'h19, 4'b0000});
        send(1'b1, ALU_ADD, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0, 1'b0,
             '{64'h00000001_00000000, 4'b0000});
        send(1'b1, ALU_SUB, 64'h00000001_00000000, 64'h1, 1'b0, 0, 1'b1,
             '{64'h00000000_FFFFFFFF, 4'b0010});
        send(1'b1, ALU_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 0, 1'b0,
             '{64'h80000000_00000000, 4'b1001});
        send(1'b1, ALU_SUB, 64'h00000005_00000005, 64'h00000005_00000005, 1'b0, 3, 1'b0,
             '{64'h0, 4'b0110});
        send(1'b0, ALU_SBC, 64'h5, 64'h5, 1'b0, 0, 1'b0, '{64'hFFFFFFFF, 4'b1000});

        // Reset pulse while the high pass is in progress discards the transaction.
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_wide = 1'b1; req_aluc = ALU_ADD;
        req_a = 64'h12345678_9ABCDEF0; req_b = 64'h1; req_cin = 1'b0;
        sb_q.push_back(model(1'b1, ALU_ADD, req_a, req_b, 1'b0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("hi_ready", 64'(req_ready), 64'd0);
        check("hi_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        check("abort_valid", 64'(rsp_valid), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_data", rsp_data, 64'd0);
        send(1'b1, ALU_ADD, 64'h00000002_FFFFFFFF, 64'h00000003_00000001, 1'b0, 0, 1'b0,
             '{64'h00000006_00000000, 4'b0000});

        for (int k = 0; k < 24; k++) begin
            op    = ops[$urandom_range(0, 8)];
            wide  = 1'($urandom_range(0, 1));
            a     = {$urandom, $urandom};
            b     = ($urandom_range(0, 5) == 0) ? a : {$urandom, $urandom};
            ci    = 1'($urandom_range(0, 1));
            hold  = $urandom_range(0, 2);
            early = (hold == 0) && ($urandom_range(0, 1) == 1);
            send(wide, op, a, b, ci, hold, early, model(wide, op, a, b, ci));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  request present.
REQ-004 req_ready  output  1  sequencer can accept; high only in IDLE.
REQ-005 req_wide  input  1  1 = 64-bit operation in two ALU passes; 0 = 32-bit, one pass.
REQ-006 req_aluc  input  4  ALU operation code, shared package encoding.
REQ-007 req_a, req_b  input  64 each  operands; narrow ops use [31:0] only.
REQ-008 req_cin  input  1  carry-in for the first (low) pass.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  64  result; [63:32] = 0 for narrow ops.
REQ-012 rsp_n, rsp_z, rsp_c, rsp_v  outputs  1 each  final negative, zero, carry, overflow flags.

Function
REQ-013 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-014 IDLE: req_ready=1; on req_valid, register req_wide, req_aluc, req_a, req_b, req_cin, then go to LO.
REQ-015 LO: drive ALU with a[31:0], b[31:0], registered aluc, registered cin; capture out, cout, negative, zero, overflow; go to HI if wide, else DONE.
REQ-016 HI: drive ALU with a[63:32], b[63:32], cin = carry captured in LO; aluc remapped ADD->ADC, SUB->SBC, all other codes unchanged; capture results; go to DONE.
REQ-017 DONE: rsp_valid=1, outputs held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-018 Latency: narrow rsp_valid asserts 2 edges after the accept edge; wide asserts 3 edges after.
REQ-019 Throughput: one transaction in flight; no request accepted outside IDLE.
REQ-020 Flags: narrow = LO-pass flags; wide N, C, V = HI-pass flags; wide Z = LO zero AND HI zero.
REQ-021 Carry convention (ALU-defined): for SUB/SBC, C=1 means no borrow; SBC computes a-b-(1-cin).
REQ-022 rsp_valid=0 and req_ready=0 in LO and HI; rsp_* outputs are don't-care except in DONE.
REQ-023 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-024 reset SHALL force IDLE and clear rsp_data, all flags, rsp_valid, and every captured register to 0 on the next edge.
REQ-025 Reset during LO, HI, or DONE SHALL discard the transaction with no response; req_ready=1 in the cycle after reset deasserts.
REQ-026 reset SHALL dominate a simultaneous handshake.

Structure
REQ-027 Shared package alu_pkg SHALL hold the aluc codes (ALU_SUB=4'b0010, ALU_ADD=4'b0100, ALU_ADC=4'b0101, ALU_SBC=4'b0110, others as the ALU defines) and the FSM state encoding.
REQ-028 alu_seq SHALL instantiate exactly one existing alu module as its sole sub-module; operand and flag muxing stay in alu_seq.

Verification
REQ-029 Narrow ADD, a=0x0000000F, b=0x0000000A, cin=0 -> rsp_data=0x19, NZCV=0000, rsp_valid 2 edges after accept.
REQ-030 Wide ADD, a=0x00000000_FFFFFFFF, b=0x1 -> rsp_data=0x00000001_00000000, C=0, Z=0, V=0, rsp_valid 3 edges after accept.
REQ-031 Wide SUB, a=0x00000001_00000000, b=0x1 -> rsp_data=0x00000000_FFFFFFFF, C=1, N=0, Z=0.
REQ-032 Wide ADD, a=0x7FFFFFFF_FFFFFFFF, b=0x1 -> rsp_data=0x80000000_00000000, N=1, V=1, C=0; wide SUB a=b=0x5_5 -> Z=1, C=1.
REQ-033 Back-pressure: rsp_ready low 3 cycles in DONE -> rsp_data and flags stable, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-034 reset pulse during HI -> next cycle rsp_valid=0, req_ready=1, rsp_data=0; the following request completes correctly.
